// File: rtl/gyro_rate_reader.sv
// Power-up wait, sensor register init, then INT-driven yaw-rate reads through a 16-bit SPI master.
// Optional done-watchdog enabled by defining GYRO_TMO_EN.
module gyro_rate_reader #(
    parameter int FAST_SIM = 1,
    parameter int TMO_CLKS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        snd,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] yaw_rt,
    output logic        tmo_err
);

    typedef enum logic [3:0] {
        PWRUP    = 4'd0,
        INIT1    = 4'd1,
        INIT2    = 4'd2,
        INIT3    = 4'd3,
        INIT4    = 4'd4,
        WAIT_INT = 4'd5,
        RD_YL    = 4'd6,
        RD_YH    = 4'd7
    } state_t;

    localparam logic [15:0] CMD_INIT1 = 16'h0D02;
    localparam logic [15:0] CMD_INIT2 = 16'h1053;
    localparam logic [15:0] CMD_INIT3 = 16'h1150;
    localparam logic [15:0] CMD_INIT4 = 16'h1460;
    localparam logic [15:0] CMD_RD_YL = 16'hA600;
    localparam logic [15:0] CMD_RD_YH = 16'hA700;

    // Power-up ends on the clock that completes 2^WAIT_POW counts since reset.
    localparam int          WAIT_POW  = (FAST_SIM != 0) ? 9 : 16;
    localparam logic [16:0] WAIT_FULL = (17'd1 << WAIT_POW) - 17'd1;
    localparam logic [15:0] WAIT_MASK = WAIT_FULL[15:0];

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        snd_q, snd_d;
    logic [15:0] cmd_q, cmd_d;
    logic        vld_q, vld_d;
    logic [15:0] yaw_rt_q, yaw_rt_d;
    logic [7:0]  yawl_q, yawl_d;
    logic        int_ff1_q, int_ff2_q;
    logic        tmo_err_q, tmo_err_d;
    logic        pwrup_done_s;
    logic        busy_s;
    logic        unused_s;

`ifdef GYRO_TMO_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CLKS - 1);
    logic [15:0] wdog_q, wdog_d;
`endif

    assign pwrup_done_s = ((timer_q & WAIT_MASK) == WAIT_MASK);
    assign busy_s       = (state_q == INIT1) || (state_q == INIT2) || (state_q == INIT3) ||
                          (state_q == INIT4) || (state_q == RD_YL) || (state_q == RD_YH);
    assign unused_s     = ^{resp[15:8], (TMO_CLKS != 0)};

    // Next-state, command issue and sample capture.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 16'd1;
        snd_d     = 1'b0;
        cmd_d     = cmd_q;
        vld_d     = 1'b0;
        yaw_rt_d  = yaw_rt_q;
        yawl_d    = yawl_q;
        tmo_err_d = tmo_err_q;

        case (state_q)
            PWRUP: begin
                if (pwrup_done_s) begin
                    state_d = INIT1;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_INIT1;
                end else begin
                    state_d = PWRUP;
                end
            end
            INIT1: begin
                if (done) begin
                    state_d = INIT2;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_INIT2;
                end else begin
                    state_d = INIT1;
                end
            end
            INIT2: begin
                if (done) begin
                    state_d = INIT3;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_INIT3;
                end else begin
                    state_d = INIT2;
                end
            end
            INIT3: begin
                if (done) begin
                    state_d = INIT4;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_INIT4;
                end else begin
                    state_d = INIT3;
                end
            end
            INIT4: begin
                if (done) begin
                    state_d = WAIT_INT;
                end else begin
                    state_d = INIT4;
                end
            end
            WAIT_INT: begin
                if (int_ff2_q) begin
                    state_d = RD_YL;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_RD_YL;
                end else begin
                    state_d = WAIT_INT;
                end
            end
            RD_YL: begin
                if (done) begin
                    yawl_d  = resp[7:0];
                    state_d = RD_YH;
                    snd_d   = 1'b1;
                    cmd_d   = CMD_RD_YH;
                end else begin
                    state_d = RD_YL;
                end
            end
            RD_YH: begin
                if (done) begin
                    yaw_rt_d = {resp[7:0], yawl_q};
                    vld_d    = 1'b1;
                    state_d  = WAIT_INT;
                end else begin
                    state_d = RD_YH;
                end
            end
            default: begin
                state_d = PWRUP;
            end
        endcase

`ifdef GYRO_TMO_EN
        // A done arriving on the last watchdog clock still wins over the timeout.
        if (busy_s && !done && (wdog_q == TMO_LAST)) begin
            tmo_err_d = 1'b1;
            state_d   = INIT1;
            snd_d     = 1'b1;
            cmd_d     = CMD_INIT1;
            vld_d     = 1'b0;
        end else begin
            tmo_err_d = tmo_err_q;
        end

        if (snd_d) begin
            wdog_d = 16'd0;
        end else if (busy_s) begin
            wdog_d = wdog_q + 16'd1;
        end else begin
            wdog_d = 16'd0;
        end
`endif
    end

    // State, timer, INT synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PWRUP;
            timer_q   <= 16'd0;
            snd_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            vld_q     <= 1'b0;
            yaw_rt_q  <= 16'h0000;
            yawl_q    <= 8'h00;
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
            tmo_err_q <= 1'b0;
`ifdef GYRO_TMO_EN
            wdog_q    <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            snd_q     <= snd_d;
            cmd_q     <= cmd_d;
            vld_q     <= vld_d;
            yaw_rt_q  <= yaw_rt_d;
            yawl_q    <= yawl_d;
            int_ff1_q <= INT;
            int_ff2_q <= int_ff1_q;
            tmo_err_q <= tmo_err_d;
`ifdef GYRO_TMO_EN
            wdog_q    <= wdog_d;
`endif
        end
    end

    assign snd     = snd_q;
    assign cmd     = cmd_q;
    assign vld     = vld_q;
    assign yaw_rt  = yaw_rt_q;
    assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_gyro_rate_reader.sv
// Self-checking bench for gyro_rate_reader: SPI slave model, yaw reference queue, vector table and random reads.
module tb_gyro_rate_reader;

    localparam logic [15:0] C_INIT1 = 16'h0D02;
    localparam logic [15:0] C_INIT2 = 16'h1053;
    localparam logic [15:0] C_INIT3 = 16'h1150;
    localparam logic [15:0] C_INIT4 = 16'h1460;
    localparam logic [15:0] C_RDYL  = 16'hA600;
    localparam logic [15:0] C_RDYH  = 16'hA700;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] resp = 16'h0000;
    logic        snd;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] yaw_rt;
    logic        tmo_err;

    gyro_rate_reader #(.FAST_SIM(1), .TMO_CLKS(1024)) dut (
        .clk(clk), .rst(rst), .INT(INT), .done(done), .resp(resp),
        .snd(snd), .cmd(cmd), .vld(vld), .yaw_rt(yaw_rt), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;
    int vld_cnt = 0;
    int last_yh_done = -100;
    int last_yh_snd = -100;
    int lat_min = 40;
    int lat_max = 40;
    bit drop_a700 = 1'b0;
    bit pend = 1'b0;
    int cnt = 0;
    logic [15:0] cur_cmd = 16'h0000;
    logic [7:0]  cur_lo = 8'h00;
    logic [7:0]  lo_q[$];
    logic [7:0]  hi_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] cmd_log[$];
    int          snd_cyc_log[$];

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] yaw;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SPI slave model plus protocol monitor, driven and sampled on the falling edge.
    always @(negedge clk) begin
        logic [7:0]  b;
        logic [15:0] e;
        done = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (vld) begin
                vld_cnt++;
                if (cyc != last_yh_done + 1) viol++;
                if (exp_q.size() == 0) begin
                    viol++;
                end else begin
                    e = exp_q.pop_front();
                    check("yaw_vs_model", {16'h0, yaw_rt}, {16'h0, e});
                end
            end
            if (snd) begin
                if (pend) viol++;
                if (cmd == C_RDYL && cyc < last_yh_done + 2) viol++;
                if (cmd == C_RDYH) last_yh_snd = cyc;
                cmd_log.push_back(cmd);
                snd_cyc_log.push_back(cyc);
                pend = 1'b1;
                cur_cmd = cmd;
                cnt = $urandom_range(lat_max, lat_min);
            end else if (pend) begin
                if (cmd !== cur_cmd) viol++;
                cnt--;
                if (cnt <= 0) begin
                    pend = 1'b0;
                    if (cur_cmd == C_RDYL) begin
                        b = (lo_q.size() > 0) ? lo_q.pop_front() : 8'($urandom);
                        cur_lo = b;
                        resp = {8'($urandom), b};
                        done = 1'b1;
                    end else if (cur_cmd == C_RDYH) begin
                        b = (hi_q.size() > 0) ? hi_q.pop_front() : 8'($urandom);
                        if (!drop_a700) begin
                            resp = {8'($urandom), b};
                            done = 1'b1;
                            exp_q.push_back({b, cur_lo});
                            last_yh_done = cyc;
                        end
                    end else begin
                        resp = 16'($urandom);
                        done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_reset(input int ncyc, input string tag);
        int n0;
        int v0;
        int rel;
        @(negedge clk);
        rst = 1'b1;
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        check({tag, "_rst_snd"}, {31'h0, snd}, 32'h0);
        check({tag, "_rst_vld"}, {31'h0, vld}, 32'h0);
        check({tag, "_rst_cmd"}, {16'h0, cmd}, 32'h0);
        check({tag, "_rst_yaw"}, {16'h0, yaw_rt}, 32'h0);
        check({tag, "_rst_tmo"}, {31'h0, tmo_err}, 32'h0);
        n0 = cmd_log.size();
        v0 = vld_cnt;
        rst = 1'b0;
        rel = cyc;
        for (int i = 0; i < 1500 && !(cmd_log.size() >= n0 + 4 && !pend); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_init_cmds_seen"}, {31'h0, (cmd_log.size() >= n0 + 4)}, 32'h1);
        if (cmd_log.size() >= n0 + 4) begin
            check({tag, "_first_snd_clk"}, snd_cyc_log[n0] - rel, 32'd512);
            check({tag, "_cmd0"}, {16'h0, cmd_log[n0]},     {16'h0, C_INIT1});
            check({tag, "_cmd1"}, {16'h0, cmd_log[n0 + 1]}, {16'h0, C_INIT2});
            check({tag, "_cmd2"}, {16'h0, cmd_log[n0 + 2]}, {16'h0, C_INIT3});
            check({tag, "_cmd3"}, {16'h0, cmd_log[n0 + 3]}, {16'h0, C_INIT4});
        end
        check({tag, "_no_extra_cmd"}, cmd_log.size() - n0, 32'd4);
        check({tag, "_no_vld_in_init"}, vld_cnt - v0, 32'd0);
    endtask

    task automatic read_one(input logic [7:0] lo, input logic [7:0] hi, input logic [15:0] expv,
                            input int width, input string tag);
        int v0;
        int n0;
        lo_q.push_back(lo);
        hi_q.push_back(hi);
        v0 = vld_cnt;
        n0 = cmd_log.size();
        @(negedge clk);
        INT = 1'b1;
        repeat (width) @(negedge clk);
        INT = 1'b0;
        for (int i = 0; i < 400 && vld_cnt == v0; i++) @(negedge clk);
        repeat (60) @(negedge clk);
        check({tag, "_vld_count"}, vld_cnt - v0, 32'd1);
        check({tag, "_yaw"}, {16'h0, yaw_rt}, {16'h0, expv});
        check({tag, "_cmd_count"}, cmd_log.size() - n0, 32'd2);
        if (cmd_log.size() >= n0 + 2) begin
            check({tag, "_cmd_yl"}, {16'h0, cmd_log[n0]},     {16'h0, C_RDYL});
            check({tag, "_cmd_yh"}, {16'h0, cmd_log[n0 + 1]}, {16'h0, C_RDYH});
        end
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int v0;
        int n0;
        int nyl;
        int nyh;
        int t;
        logic [7:0] rl;
        logic [7:0] rh;

        tbl[0] = '{lo: 8'h34, hi: 8'h12, yaw: 16'h1234};
        tbl[1] = '{lo: 8'h00, hi: 8'hF8, yaw: 16'hF800};
        tbl[2] = '{lo: 8'hFF, hi: 8'h7F, yaw: 16'h7FFF};
        tbl[3] = '{lo: 8'h00, hi: 8'h80, yaw: 16'h8000};
        tbl[4] = '{lo: 8'hFF, hi: 8'hFF, yaw: 16'hFFFF};
        tbl[5] = '{lo: 8'h01, hi: 8'h00, yaw: 16'h0001};

        do_reset(2, "pwrup");

        for (int i = 0; i < 6; i++) begin
            read_one(tbl[i].lo, tbl[i].hi, tbl[i].yaw, 3, $sformatf("vec%0d", i));
        end

        lat_min = 1;
        for (int i = 0; i < 10; i++) begin
            lat_max = $urandom_range(20, 1);
            rl = 8'($urandom);
            rh = 8'($urandom);
            read_one(rl, rh, {rh, rl}, $urandom_range(4, 1), $sformatf("rnd%0d", i));
        end

        // INT held high: back-to-back reads until three have been launched.
        lat_min = 3;
        lat_max = 12;
        v0 = vld_cnt;
        n0 = cmd_log.size();
        @(negedge clk);
        INT = 1'b1;
        for (int i = 0; i < 600; i++) begin
            nyl = 0;
            for (int k = n0; k < cmd_log.size(); k++) if (cmd_log[k] == C_RDYL) nyl++;
            if (nyl >= 3) break;
            @(negedge clk);
        end
        INT = 1'b0;
        for (int i = 0; i < 400 && (vld_cnt - v0) < 3; i++) @(negedge clk);
        repeat (80) @(negedge clk);
        nyl = 0;
        nyh = 0;
        for (int k = n0; k < cmd_log.size(); k++) begin
            if (cmd_log[k] == C_RDYL) nyl++;
            if (cmd_log[k] == C_RDYH) nyh++;
        end
        check("b2b_vld", vld_cnt - v0, 32'd3);
        check("b2b_yl", nyl, 32'd3);
        check("b2b_yh", nyh, 32'd3);

        // Reset while a low-byte read is outstanding.
        lat_min = 40;
        lat_max = 40;
        n0 = cmd_log.size();
        @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        for (int i = 0; i < 50 && cmd_log.size() == n0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("midrd_in_yl", {16'h0, cur_cmd}, {16'h0, C_RDYL});
        do_reset(1, "midrd");
        read_one(8'h34, 8'h12, 16'h1234, 3, "post_rst");

`ifdef GYRO_TMO_EN
        lat_min = 10;
        lat_max = 10;
        drop_a700 = 1'b1;
        v0 = vld_cnt;
        t = last_yh_snd;
        @(negedge clk);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        for (int i = 0; i < 200 && last_yh_snd == t; i++) @(negedge clk);
        t = last_yh_snd;
        n0 = cmd_log.size();
        for (int i = 0; i < 1200 && !tmo_err; i++) @(negedge clk);
        check("tmo_clk", cyc - t, 32'd1024);
        drop_a700 = 1'b0;
        for (int i = 0; i < 400 && !(cmd_log.size() >= n0 + 4 && !pend); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        if (cmd_log.size() > n0) check("tmo_resend", {16'h0, cmd_log[n0]}, {16'h0, C_INIT1});
        else check("tmo_resend_seen", cmd_log.size() - n0, 32'd1);
        check("tmo_sticky", {31'h0, tmo_err}, 32'h1);
        check("tmo_no_vld", vld_cnt - v0, 32'd0);
        exp_q.delete();
`else
        check("tmo_tied_low", {31'h0, tmo_err}, 32'h0);
`endif

        check("protocol_violations", viol, 32'd0);
        check("model_queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
